// File: rtl/sorted_region_checker_pkg.sv
// Purpose: shared types, constants and the ordering predicate for the sorted-region checker.
// Latency: n/a (types and a combinational helper only).
// Backpressure: n/a.
package check_pkg;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        READ = 2'd1,
        DONE = 2'd2
    } chk_state_t;

    // Canonical RISC-V NOP (addi x0, x0, 0), the default end-of-program sentinel.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Operands are widened to this width before comparison; data words up to 64 bits are supported.
    localparam int CMP_W = 64;

    // True when the pair (prev, cur) respects the requested order.
    // Equal neighbours are always in order. Callers sign- or zero-extend to CMP_W.
    function automatic logic in_order(input logic [CMP_W-1:0] prev,
                                      input logic [CMP_W-1:0] cur,
                                      input logic             order,
                                      input logic             signed_cmp);
        logic le;
        logic ge;
        if (signed_cmp) begin
            le = ($signed(prev) <= $signed(cur));
            ge = ($signed(prev) >= $signed(cur));
        end else begin
            le = (prev <= cur);
            ge = (prev >= cur);
        end
        return order ? ge : le;
    endfunction

endpackage

// File: rtl/sorted_region_checker_if.sv
// Purpose: bundles the instruction tap, the data-memory read port and the status outputs.
// Latency: n/a (wires only).
// Backpressure: none; read data is expected exactly one cycle after a read request.
interface sorted_region_checker_if #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int NUM_WORDS = 8
);
    localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    logic [31:0]       instr;
    logic              instr_valid;
    logic              chk_rd_en;
    logic [ADDR_W-1:0] chk_addr;
    logic [DATA_W-1:0] chk_rd_data;
    logic              busy;
    logic              done;
    logic              pass;
    logic              fail;
    logic              timed_out;
    logic [IDX_W-1:0]  mismatch_idx;
    logic [31:0]       cycle_count;

    // Core / memory side: supplies fetches and read data, observes the verdict.
    modport master (
        output instr, instr_valid, chk_rd_data,
        input  chk_rd_en, chk_addr, busy, done, pass, fail, timed_out, mismatch_idx, cycle_count
    );

    // Checker side.
    modport slave (
        input  instr, instr_valid, chk_rd_data,
        output chk_rd_en, chk_addr, busy, done, pass, fail, timed_out, mismatch_idx, cycle_count
    );

endinterface

// File: rtl/sorted_region_checker_sentinel.sv
// Purpose: spots END_REPEAT consecutive valid fetches of the sentinel word and pulses end_seen.
// Latency: combinational pulse in the cycle the final sentinel fetch is presented.
// Backpressure: none; invalid cycles hold the run count, any other valid word clears it.
module end_sentinel_detector
    import check_pkg::*;
#(
    parameter logic [31:0] END_INSTR  = NOP_INSTR,
    parameter int          END_REPEAT = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        instr_valid,
    output logic        end_seen
);
    localparam int CNT_W = $clog2(END_REPEAT + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(END_REPEAT - 1);

    logic [CNT_W-1:0] run_cnt;
    logic             hit;

    assign hit      = instr_valid && (instr == END_INSTR);
    assign end_seen = hit && (run_cnt == LAST_CNT);

    // Count back-to-back sentinel fetches; restart after a detection so the count never overflows.
    always_ff @(posedge clk) begin
        if (reset) begin
            run_cnt <= '0;
        end else if (instr_valid) begin
            if (!hit || end_seen) begin
                run_cnt <= '0;
            end else begin
                run_cnt <= run_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sorted_region_checker.sv
// Purpose: waits for program end, then walks a data-memory region checking it is sorted.
// Latency: verdict NUM_WORDS+1 cycles after the sentinel detect (one read per cycle, 1-cycle compare lag).
// Backpressure: none; reads are issued back to back and data must return exactly one cycle later.
module sorted_region_checker
    import check_pkg::*;
#(
    parameter int                DATA_W     = 32,
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
    parameter int                NUM_WORDS  = 8,
    parameter int                ORDER      = 0,
    parameter int                SIGNED_CMP = 1,
    parameter logic [31:0]       END_INSTR  = NOP_INSTR,
    parameter int                END_REPEAT = 3,
    parameter int                TIMEOUT    = 100000
) (
    input  logic                    clk,
    input  logic                    reset,
    sorted_region_checker_if.slave  bus
);
    localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_WORDS - 1);
    localparam logic [31:0]       TMO_LAST  = 32'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] STRIDE    = ADDR_W'(DATA_W / 8);
    // Upper bits set when widening a negative DATA_W word to CMP_W.
    localparam logic [CMP_W-1:0]  SEXT_MASK = ~((CMP_W'(1) << DATA_W) - CMP_W'(1));

    chk_state_t        state;
    chk_state_t        state_nxt;
    logic              timeout_hit;
    logic              end_seen;

    logic [IDX_W-1:0]  rd_idx;
    logic              rd_issued;
    logic              rd_en;
    logic              rd_vld;
    logic [IDX_W-1:0]  rd_vld_idx;
    logic              last_cmp;

    logic [DATA_W-1:0] prev;
    logic [CMP_W-1:0]  prev_x;
    logic [CMP_W-1:0]  cur_x;
    logic              cmp_ok;

    logic              mis_flag;
    logic [IDX_W-1:0]  mis_idx;
    logic              tmo;
    logic [31:0]       cyc;

    end_sentinel_detector #(
        .END_INSTR  (END_INSTR),
        .END_REPEAT (END_REPEAT)
    ) u_sentinel (
        .clk         (clk),
        .reset       (reset),
        .instr       (bus.instr),
        .instr_valid (bus.instr_valid),
        .end_seen    (end_seen)
    );

    // A read goes out every READ cycle until the last index has been requested; never during reset.
    assign rd_en    = (state == READ) && !rd_issued && !reset;
    assign last_cmp = rd_vld && (rd_vld_idx == LAST_IDX);

    // Next-state logic: sentinel beats timeout; READ ends once the last word has been compared.
    always_comb begin
        state_nxt   = state;
        timeout_hit = 1'b0;
        case (state)
            RUN: begin
                if (end_seen) begin
                    state_nxt = READ;
                end else if (cyc == TMO_LAST) begin
                    state_nxt   = DONE;
                    timeout_hit = 1'b1;
                end
            end
            READ: begin
                if (last_cmp) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = DONE;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    // State register; reset aborts any walk in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Read index: advances per request and parks on the last index instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_idx    <= '0;
            rd_issued <= 1'b0;
        end else if (rd_en) begin
            if (rd_idx == LAST_IDX) begin
                rd_issued <= 1'b1;
            end else begin
                rd_idx <= rd_idx + 1'b1;
            end
        end
    end

    // Tag returning data with its index, one cycle behind the request.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_vld     <= 1'b0;
            rd_vld_idx <= '0;
        end else begin
            rd_vld     <= rd_en;
            rd_vld_idx <= rd_idx;
        end
    end

    // Widen both operands so one predicate covers signed and unsigned data.
    always_comb begin
        prev_x = CMP_W'(prev);
        cur_x  = CMP_W'(bus.chk_rd_data);
        if (SIGNED_CMP != 0) begin
            if (prev[DATA_W-1]) begin
                prev_x = prev_x | SEXT_MASK;
            end
            if (bus.chk_rd_data[DATA_W-1]) begin
                cur_x = cur_x | SEXT_MASK;
            end
        end
        cmp_ok = in_order(prev_x, cur_x, ORDER != 0, SIGNED_CMP != 0);
    end

    // Word 0 only seeds prev; later words are checked and only the first violation is recorded.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev     <= '0;
            mis_flag <= 1'b0;
            mis_idx  <= '0;
        end else if (rd_vld) begin
            prev <= bus.chk_rd_data;
            if ((rd_vld_idx != '0) && !cmp_ok && !mis_flag) begin
                mis_flag <= 1'b1;
                mis_idx  <= rd_vld_idx;
            end
        end
    end

    // Cycle counter runs only while staying in RUN, so it freezes on detect or timeout; saturates.
    always_ff @(posedge clk) begin
        if (reset) begin
            cyc <= '0;
        end else if ((state == RUN) && (state_nxt == RUN) && (cyc != '1)) begin
            cyc <= cyc + 32'd1;
        end
    end

    // Sticky timeout flag, raised together with the move to DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo <= 1'b0;
        end else if (timeout_hit) begin
            tmo <= 1'b1;
        end
    end

    assign bus.chk_rd_en    = rd_en;
    assign bus.chk_addr     = rd_en ? (BASE_ADDR + (ADDR_W'(rd_idx) * STRIDE)) : '0;
    assign bus.busy         = (state != DONE);
    assign bus.done         = (state == DONE);
    assign bus.pass         = (state == DONE) && !mis_flag && !tmo;
    assign bus.fail         = (state == DONE) && (mis_flag || tmo);
    assign bus.timed_out    = tmo;
    assign bus.mismatch_idx = mis_idx;
    assign bus.cycle_count  = cyc;

endmodule

// File: tb/tb_sorted_region_checker.sv
// Purpose: directed bench for sorted_region_checker across ascending, descending and timeout builds.
// Latency: expects verdict NUM_WORDS+2 negedges after the final sentinel fetch is driven.
// Backpressure: n/a; memory models answer every read one cycle later.
module tb_sorted_region_checker;
    import check_pkg::*;

    localparam logic [31:0] ADDI = 32'h0015_0513;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a = 1'b1;
    logic        rst_d = 1'b1;
    logic        rst_t = 1'b1;
    logic [31:0] instr = '0;
    logic        instr_valid = 1'b0;

    int checks   = 0;
    int failures = 0;

    sorted_region_checker_if ifa ();
    sorted_region_checker_if ifs ();
    sorted_region_checker_if ifu ();
    sorted_region_checker_if ift ();

    assign ifa.instr = instr;  assign ifa.instr_valid = instr_valid;
    assign ifs.instr = instr;  assign ifs.instr_valid = instr_valid;
    assign ifu.instr = instr;  assign ifu.instr_valid = instr_valid;
    assign ift.instr = instr;  assign ift.instr_valid = instr_valid;

    sorted_region_checker u_asc (.clk(clk), .reset(rst_a), .bus(ifa));
    sorted_region_checker #(.ORDER(1), .SIGNED_CMP(1)) u_dsg (.clk(clk), .reset(rst_d), .bus(ifs));
    sorted_region_checker #(.ORDER(1), .SIGNED_CMP(0)) u_dus (.clk(clk), .reset(rst_d), .bus(ifu));
    sorted_region_checker #(.TIMEOUT(50)) u_tmo (.clk(clk), .reset(rst_t), .bus(ift));

    logic [31:0] mem_a [8];
    logic [31:0] mem_d [8];
    logic [31:0] alog  [64];
    int          nrd_a = 0;
    int          nrd_t = 0;
    logic [3:0]  done_v;

    assign done_v = {ift.done, ifu.done, ifs.done, ifa.done};
    assign ift.chk_rd_data = '0;

    // Memory model for the ascending build, with a log of requested addresses.
    always @(posedge clk) begin
        if (ifa.chk_rd_en) begin
            ifa.chk_rd_data    <= mem_a[ifa.chk_addr[4:2]];
            alog[nrd_a[5:0]]   <= ifa.chk_addr;
            nrd_a              <= nrd_a + 1;
        end
    end

    // Memory models for the two descending builds (same data).
    always @(posedge clk) begin
        if (ifs.chk_rd_en) ifs.chk_rd_data <= mem_d[ifs.chk_addr[4:2]];
        if (ifu.chk_rd_en) ifu.chk_rd_data <= mem_d[ifu.chk_addr[4:2]];
    end

    // The timeout build must never read.
    always @(posedge clk) begin
        if (ift.chk_rd_en) nrd_t <= nrd_t + 1;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic fetch(input logic [31:0] w, input logic v);
        @(negedge clk);
        instr       = w;
        instr_valid = v;
    endtask

    task automatic nops3();
        for (int k = 0; k < 3; k++) fetch(NOP_INSTR, 1'b1);
    endtask

    // Counts negedges until the selected DUT reports done; a bound of lim stands for a hang.
    task automatic wait_done(input int w, input int lim, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            instr_valid = 1'b0;
            lat++;
        end while (!done_v[w] && (lat < lim));
    endtask

    task automatic reset_a();
        @(negedge clk);
        rst_a = 1'b1;
        instr_valid = 1'b0;
        @(negedge clk);
        rst_a = 1'b0;
    endtask

    int lat;
    int base;

    initial begin
        mem_a = '{32'd1, 32'd2, 32'd2, 32'd5, 32'd7, 32'd9, 32'd10, 32'd40};
        mem_d = '{32'd5, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9,
                  32'hFFFF_FFF8, 32'hFFFF_FFEC, 32'hFFFF_FF9C, 32'hFFFF_FC18};
        repeat (2) @(negedge clk);

        // Reset state while reset is held.
        check_eq("rst_busy",   ifa.busy,         1);
        check_eq("rst_done",   ifa.done,         0);
        check_eq("rst_pass",   ifa.pass,         0);
        check_eq("rst_fail",   ifa.fail,         0);
        check_eq("rst_tmo",    ifa.timed_out,    0);
        check_eq("rst_rden",   ifa.chk_rd_en,    0);
        check_eq("rst_cyc",    ifa.cycle_count,  0);
        check_eq("rst_idx",    ifa.mismatch_idx, 0);

        // Sorted ascending region with plain 3-NOP end.
        rst_a = 1'b0;
        base  = nrd_a;
        nops3();
        wait_done(0, 40, lat);
        check_eq("asc_lat",   lat, 10);
        check_eq("asc_pass",  ifa.pass, 1);
        check_eq("asc_fail",  ifa.fail, 0);
        check_eq("asc_idx",   ifa.mismatch_idx, 0);
        check_eq("asc_cyc",   ifa.cycle_count, 3);
        check_eq("asc_reads", nrd_a - base, 8);
        for (int k = 0; k < 8; k++) check_eq($sformatf("asc_addr%0d", k), alog[(base + k) % 64], 4 * k);
        check_eq("asc_busy",  ifa.busy, 0);
        check_eq("asc_rden",  ifa.chk_rd_en, 0);
        check_eq("asc_tmo",   ifa.timed_out, 0);

        // Two violations: only the first (index 3) is reported, walk still completes.
        mem_a = '{32'd1, 32'd2, 32'd9, 32'd3, 32'd4, 32'd8, 32'd0, 32'd12};
        reset_a();
        base = nrd_a;
        nops3();
        wait_done(0, 40, lat);
        check_eq("bad_lat",   lat, 10);
        check_eq("bad_fail",  ifa.fail, 1);
        check_eq("bad_pass",  ifa.pass, 0);
        check_eq("bad_idx",   ifa.mismatch_idx, 3);
        check_eq("bad_reads", nrd_a - base, 8);

        // Interrupted sentinel run and invalid gaps.
        mem_a = '{32'd1, 32'd2, 32'd2, 32'd5, 32'd7, 32'd9, 32'd10, 32'd40};
        reset_a();
        fetch(NOP_INSTR, 1'b1);
        fetch(NOP_INSTR, 1'b1);
        fetch(ADDI,      1'b1);
        fetch(NOP_INSTR, 1'b1);
        fetch(ADDI,      1'b0);
        fetch(NOP_INSTR, 1'b1);
        fetch(NOP_INSTR, 1'b0);
        @(negedge clk);
        check_eq("sen_early_rden", ifa.chk_rd_en, 0);
        check_eq("sen_early_busy", ifa.busy, 1);
        instr       = NOP_INSTR;
        instr_valid = 1'b1;
        wait_done(0, 40, lat);
        check_eq("sen_lat",  lat, 10);
        check_eq("sen_cyc",  ifa.cycle_count, 8);
        check_eq("sen_pass", ifa.pass, 1);

        // Reset while reading index 4, then a clean rerun on failing data.
        mem_a = '{32'd1, 32'd2, 32'd9, 32'd3, 32'd4, 32'd8, 32'd0, 32'd12};
        reset_a();
        base = nrd_a;
        nops3();
        @(negedge clk);
        instr_valid = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("mid_rden_before", ifa.chk_rd_en, 1);
        check_eq("mid_addr_before", ifa.chk_addr, 32'h10);
        rst_a = 1'b1;
        #1;
        check_eq("mid_rden_rstcyc", ifa.chk_rd_en, 0);
        @(negedge clk);
        check_eq("mid_busy",  ifa.busy, 1);
        check_eq("mid_done",  ifa.done, 0);
        check_eq("mid_rden",  ifa.chk_rd_en, 0);
        check_eq("mid_reads", nrd_a - base, 4);
        check_eq("mid_idx",   ifa.mismatch_idx, 0);
        rst_a = 1'b0;
        base  = nrd_a;
        nops3();
        wait_done(0, 40, lat);
        check_eq("rerun_lat",   lat, 10);
        check_eq("rerun_fail",  ifa.fail, 1);
        check_eq("rerun_idx",   ifa.mismatch_idx, 3);
        check_eq("rerun_reads", nrd_a - base, 8);
        check_eq("rerun_cyc",   ifa.cycle_count, 3);
        rst_a = 1'b1;

        // Descending region: passes signed, fails unsigned at index 2 (0 vs 0xFFFFFFFF).
        @(negedge clk);
        rst_d = 1'b0;
        nops3();
        wait_done(1, 40, lat);
        check_eq("dsg_lat",  lat, 10);
        check_eq("dsg_pass", ifs.pass, 1);
        check_eq("dsg_idx",  ifs.mismatch_idx, 0);
        check_eq("dus_done", ifu.done, 1);
        check_eq("dus_fail", ifu.fail, 1);
        check_eq("dus_pass", ifu.pass, 0);
        check_eq("dus_idx",  ifu.mismatch_idx, 2);
        rst_d = 1'b1;

        // Timeout with no valid sentinel (sentinel word present but never valid).
        @(negedge clk);
        instr       = NOP_INSTR;
        instr_valid = 1'b0;
        rst_t       = 1'b0;
        wait_done(3, 200, lat);
        check_eq("tmo_lat",   lat, 50);
        check_eq("tmo_done",  ift.done, 1);
        check_eq("tmo_flag",  ift.timed_out, 1);
        check_eq("tmo_fail",  ift.fail, 1);
        check_eq("tmo_pass",  ift.pass, 0);
        check_eq("tmo_cyc",   ift.cycle_count, 49);
        check_eq("tmo_reads", nrd_t, 0);
        check_eq("tmo_busy",  ift.busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
